// File: rtl/sequential_group_borrow_subtractor_pkg.sv
// Shared types and defaults for the group-serial borrow-lookahead subtractor.
package sequential_group_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_GROUP_WIDTH = 4;
  localparam int DEFAULT_GROUP_COUNT = 2;

  // Group index width. It never drops below one bit, so a single-group build still has a legal counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequential_group_borrow_subtractor_lookahead.sv
// One GROUP_WIDTH slice of subtraction: a - b - borrow_in using prefix generate/propagate borrows.
module group_borrow_lookahead #(
  parameter int GROUP_WIDTH = 4
) (
  input  logic [GROUP_WIDTH-1:0] a,
  input  logic [GROUP_WIDTH-1:0] b,
  input  logic                   borrow_in,
  output logic [GROUP_WIDTH-1:0] d,
  output logic                   borrow_out
);

  logic [GROUP_WIDTH-1:0] gen;
  logic [GROUP_WIDTH-1:0] prop;
  logic [GROUP_WIDTH:0]   brw;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign gen  = ~a & b;
  assign prop = ~(a ^ b);

  always_comb begin
    logic gg;
    logic pp;
    gg     = 1'b0;
    pp     = 1'b1;
    brw    = '0;
    brw[0] = borrow_in;
    for (int i = 0; i < GROUP_WIDTH; i++) begin
      gg         = gen[i] | (prop[i] & gg);
      pp         = prop[i] & pp;
      brw[i + 1] = gg | (pp & borrow_in);
    end
  end

  assign d          = a ^ b ^ brw[GROUP_WIDTH-1:0];
  assign borrow_out = brw[GROUP_WIDTH];

endmodule

// File: rtl/sequential_group_borrow_subtractor.sv
// Group-serial subtractor: one borrow-lookahead slice per cycle, LSB group first, registered results.
module sequential_group_borrow_subtractor
  import sequential_group_borrow_subtractor_pkg::*;
#(
  parameter int GROUP_WIDTH = DEFAULT_GROUP_WIDTH,
  parameter int GROUP_COUNT = DEFAULT_GROUP_COUNT,
  parameter int WIDTH       = GROUP_COUNT * GROUP_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int               IDX_W    = idx_width(GROUP_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_COUNT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic             borrow_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  int                     base;
  logic [GROUP_WIDTH-1:0] grp_a;
  logic [GROUP_WIDTH-1:0] grp_b;
  logic [GROUP_WIDTH-1:0] grp_d;
  logic                   grp_borrow;
  logic                   last_grp;
  logic                   overflow_d;

  assign base     = int'(idx_q) * GROUP_WIDTH;
  assign grp_a    = x_q[base +: GROUP_WIDTH];
  assign grp_b    = y_q[base +: GROUP_WIDTH];
  assign last_grp = (idx_q == LAST_IDX);
  assign idx_d    = last_grp ? '0 : idx_q + 1'b1;

  // The last slice carries the result MSB, so signed overflow is decided in that cycle.
  assign overflow_d = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (grp_d[GROUP_WIDTH-1] != x_q[WIDTH-1]);

  group_borrow_lookahead #(
    .GROUP_WIDTH(GROUP_WIDTH)
  ) u_group (
    .a         (grp_a),
    .b         (grp_b),
    .borrow_in (borrow_q),
    .d         (grp_d),
    .borrow_out(grp_borrow)
  );

  // borrow_q is the running inter-group borrow; once the run ends it is the final borrow_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            x_q        <= x;
            y_q        <= y;
            borrow_q   <= borrow_in;
            idx_q      <= '0;
            z_q        <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_RUN: begin
          z_q[base +: GROUP_WIDTH] <= grp_d;
          borrow_q                 <= grp_borrow;
          idx_q                    <= idx_d;
          if (last_grp) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            overflow_q <= overflow_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign z          = z_q;
  assign borrow_out = borrow_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sequential_group_borrow_subtractor.sv
// Directed and reference-model bench for the group-serial subtractor at default parameters (WIDTH=8).
module tb_sequential_group_borrow_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         borrow_out;
  logic         overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W:0]   full;
  logic [W-1:0] rx;
  logic [W-1:0] ry;
  logic         rb;
  logic         eov;

  always #5 clk = ~clk;

  sequential_group_borrow_subtractor dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .z         (z),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic ab);
    x         = ax;
    y         = ay;
    borrow_in = ab;
    start     = 1'b1;
  endtask

  // Full transaction: start in cycle 0, busy in 1..2, done in 3, results held in 4.
  task automatic run_op(input string tag, input logic [W-1:0] ax, input logic [W-1:0] ay,
                        input logic ab, input logic [W-1:0] ez, input logic eb, input logic eo);
    do_start(ax, ay, ab);
    step();
    start     = 1'b0;
    x         = W'($urandom_range(0, 255));
    y         = W'($urandom_range(0, 255));
    borrow_in = 1'($urandom_range(0, 1));
    chk({tag, "_c1_busy"}, busy, 1);
    chk({tag, "_c1_done"}, done, 0);
    step();
    chk({tag, "_c2_busy"}, busy, 1);
    chk({tag, "_c2_done"}, done, 0);
    step();
    chk({tag, "_c3_done"}, done, 1);
    chk({tag, "_c3_busy"}, busy, 0);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_borrow"}, borrow_out, eb);
    chk({tag, "_ovf"}, overflow, eo);
    step();
    chk({tag, "_c4_done"}, done, 0);
    chk({tag, "_c4_zhold"}, z, ez);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    x         = '0;
    y         = '0;
    borrow_in = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z", z, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    step();

    run_op("basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("neg_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    run_op("zero_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ff_ff_bin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ovf_00_80", 8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ovf_a5_5a_bin", 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);
    run_op("grp_borrow_18_09", 8'h18, 8'h09, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Start during RUN must be ignored.
    do_start(8'h5A, 8'h3C, 1'b0);
    step();
    do_start(8'hFF, 8'h01, 1'b0);
    step();
    start = 1'b0;
    step();
    chk("ign_done", done, 1);
    chk("ign_z", z, 8'h1E);
    step();
    chk("ign_single_done", done, 0);
    chk("ign_not_busy", busy, 0);
    chk("ign_zhold", z, 8'h1E);

    // Start in the done cycle is accepted back-to-back.
    do_start(8'h5A, 8'h3C, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    chk("b2b_done1", done, 1);
    chk("b2b_z1", z, 8'h1E);
    do_start(8'h33, 8'h11, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_c4_busy", busy, 1);
    chk("b2b_c4_done", done, 0);
    step();
    step();
    chk("b2b_done2", done, 1);
    chk("b2b_z2", z, 8'h22);
    chk("b2b_borrow2", borrow_out, 0);
    step();

    // Reset during RUN aborts with no done pulse.
    do_start(8'hC3, 8'h21, 1'b1);
    step();
    start = 1'b0;
    reset = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_z", z, 0);
    chk("abort_borrow", borrow_out, 0);
    chk("abort_ovf", overflow, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end

    // Start in the first cycle after reset deasserts.
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_start(8'h80, 8'h01, 1'b0);
    step();
    start = 1'b0;
    chk("post_rst_busy", busy, 1);
    step();
    step();
    chk("post_rst_done", done, 1);
    chk("post_rst_z", z, 8'h7F);
    chk("post_rst_ovf", overflow, 1);
    step();

    // Reference model: 9-bit unsigned difference gives z and borrow; overflow from sign bits.
    for (int k = 0; k < 1000; k++) begin
      rx   = W'($urandom_range(0, 255));
      ry   = W'($urandom_range(0, 255));
      rb   = 1'($urandom_range(0, 1));
      full = {1'b0, rx} - {1'b0, ry} - {{W{1'b0}}, rb};
      eov  = (rx[W-1] != ry[W-1]) && (full[W-1] != rx[W-1]);
      do_start(rx, ry, rb);
      step();
      start = 1'b0;
      step();
      step();
      chk("rnd_done", done, 1);
      chk("rnd_z", z, full[W-1:0]);
      chk("rnd_borrow", borrow_out, full[W]);
      chk("rnd_ovf", overflow, eov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sequential_group_borrow_subtractor.md
SEQUENTIAL_GROUP_BORROW_SUBTRACTOR -- requirements
Module: sequential_group_borrow_subtractor

Interface
REQ-001 SHALL have parameter GROUP_WIDTH, default 4, bits per borrow-lookahead group.
REQ-002 SHALL have parameter GROUP_COUNT, default 2, number of groups processed serially.
REQ-003 SHALL have parameter WIDTH, default GROUP_COUNT*GROUP_WIDTH, operand width (derived; not overridden independently).
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; x, y and borrow_in are sampled on the same edge.
REQ-007 SHALL have port x  input  WIDTH  minuend.
REQ-008 SHALL have port y  input  WIDTH  subtrahend.
REQ-009 SHALL have port borrow_in  input  1  initial borrow.
REQ-010 SHALL have port busy  output  1  high while groups are being processed.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port z  output  WIDTH  difference x - y - borrow_in mod 2^WIDTH.
REQ-013 SHALL have port borrow_out  output  1  unsigned borrow: 1 iff x < y + borrow_in.
REQ-014 SHALL have port overflow  output  1  two's-complement overflow of x - y - borrow_in.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL capture x, y, borrow_in, clear the group index and enter RUN.
REQ-017 In RUN, each cycle SHALL compute one GROUP_WIDTH slice, LSB group first, using group generate/propagate borrow lookahead. The incoming borrow is the previous group's borrow, or the captured borrow_in for group 0.
REQ-018 In RUN, each cycle SHALL write the slice into z, store the group borrow and increment the index.
REQ-019 After the group with index GROUP_COUNT-1, the block SHALL enter DONE.
REQ-020 Latency is fixed: start high in cycle 0, busy high in cycles 1..GROUP_COUNT, done high only in cycle GROUP_COUNT+1.
REQ-021 start asserted while in RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-022 done SHALL be high exactly one cycle per accepted start. It SHALL be high only in the first DONE cycle.
REQ-023 z, borrow_out and overflow SHALL hold their final values from the done cycle until the next accepted start.
REQ-024 DONE SHALL persist until start; start in the done cycle SHALL be accepted (back-to-back operation).
REQ-025 overflow SHALL equal (x[MSB] != y[MSB]) && (z[MSB] != x[MSB]), evaluated on the captured operands.
REQ-026 z, borrow_out and overflow SHALL be register outputs; there is no combinational path from inputs to outputs.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, with busy=0, done=0, z=0, borrow_out=0, overflow=0 and index=0.
REQ-028 reset SHALL take priority over start and SHALL abort a RUN in progress with no done pulse.
REQ-029 A start in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the state enumeration and default GROUP_WIDTH/GROUP_COUNT constants.
REQ-031 Per-group logic SHALL be one sub-module, group_borrow_lookahead. It is combinational, GROUP_WIDTH-parameterised, with inputs a, b, borrow_in and outputs d, borrow_out.
REQ-032 The top level SHALL contain the FSM, group index counter, operand registers and result registers only.

Verification (defaults, WIDTH=8; N = GROUP_COUNT+1 = 3)
REQ-033 x=0x5A, y=0x3C, borrow_in=0, start -> done in cycle 3; z=0x1E, borrow_out=0, overflow=0.
REQ-034 x=0x10, y=0x20, borrow_in=0 -> z=0xF0, borrow_out=1, overflow=0. Separately, x=0x00, y=0x00, borrow_in=1 -> z=0xFF, borrow_out=1, overflow=0.
REQ-035 x=0x80, y=0x01, borrow_in=0 -> z=0x7F, borrow_out=0, overflow=1.
REQ-036 Start 0x5A-0x3C, then start with 0xFF-0x01 in cycle 1 (during RUN) -> single done in cycle 3 with z=0x1E.
REQ-037 Start 0x5A-0x3C, then start 0x33-0x11 in the done cycle -> second done 3 cycles later, z=0x22.
REQ-038 Start, then reset in cycle 1 -> no done pulse, and all outputs are 0 in the cycle after reset.
REQ-039 Random test: 1000 random x, y, borrow_in triples compared against a reference model for z, borrow_out and overflow.
